core_id_ex_stage: RTL and testbench

ID/EX pipeline register of the RV32I core. It captures the decoded instruction and its register-file operands, resolves data hazards by forwarding from the MEM and WB stages, and detects load-use hazards. It drives the operand, immediate and function fields consumed directly by the execute-stage ALU (`core_alu`). It sits between decode/register-read and the ALU.

---
 rtl/core_id_ex_stage.sv | 121 ++++++++++++
 tb/tb_core_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction, forwards MEM/WB
// results into the ALU operands and flags load-use hazards to the front end.
module core_id_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_id_valid,
    input  logic [6:0]  i_id_opcode,
    input  logic [6:0]  i_id_funct7,
    input  logic [2:0]  i_id_funct3,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic [4:0]  i_id_rd,
    input  logic        i_id_rd_we,
    input  logic        i_id_is_load,
    input  logic [31:0] i_id_rs1_val,
    input  logic [31:0] i_id_rs2_val,
    input  logic [31:0] i_id_immu,
    input  logic [31:0] i_id_pc,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_rd_we,
    input  logic [31:0] i_mem_res,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_rd_we,
    input  logic [31:0] i_wb_data,
    output logic        o_valid,
    output logic [6:0]  o_opcode,
    output logic [6:0]  o_funct7,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_num1u,
    output logic [31:0] o_num2u,
    output logic [31:0] o_immu,
    output logic [31:0] o_pc_immu,
    output logic [4:0]  o_rd,
    output logic        o_rd_we,
    output logic        o_is_load,
    output logic        o_load_use_stall
);
    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] immu;
        logic [31:0] pc_immu;
    } ex_t;

    ex_t ex_q, ex_d;

    logic wb_hit_id1, wb_hit_id2, wb_hit_q1, wb_hit_q2, mem_hit1, mem_hit2;

    // x0 is never a forwarding target.
    function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd == rs) && (rs != 5'd0);
    endfunction

    assign wb_hit_id1 = FWD_EN && hit(i_wb_rd_we, i_wb_rd, i_id_rs1);
    assign wb_hit_id2 = FWD_EN && hit(i_wb_rd_we, i_wb_rd, i_id_rs2);
    assign wb_hit_q1  = FWD_EN && hit(i_wb_rd_we, i_wb_rd, ex_q.rs1);
    assign wb_hit_q2  = FWD_EN && hit(i_wb_rd_we, i_wb_rd, ex_q.rs2);
    assign mem_hit1   = FWD_EN && hit(i_mem_rd_we, i_mem_rd, ex_q.rs1);
    assign mem_hit2   = FWD_EN && hit(i_mem_rd_we, i_mem_rd, ex_q.rs2);

    // Conservative: rs2 is compared even for instructions that ignore it.
    assign o_load_use_stall = ex_q.valid & ex_q.is_load & ex_q.rd_we & (ex_q.rd != 5'd0)
                            & i_id_valid & ((ex_q.rd == i_id_rs1) | (ex_q.rd == i_id_rs2));

    always_comb begin
        ex_d = ex_q;
        if (i_flush) begin
            ex_d = '0;
        end else if (i_stall) begin
            // Keep a value that retires from WB while we are held.
            if (wb_hit_q1) ex_d.op1 = i_wb_data;
            if (wb_hit_q2) ex_d.op2 = i_wb_data;
        end else if (o_load_use_stall || !i_id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid   = 1'b1;
            ex_d.opcode  = i_id_opcode;
            ex_d.funct7  = i_id_funct7;
            ex_d.funct3  = i_id_funct3;
            ex_d.rs1     = i_id_rs1;
            ex_d.rs2     = i_id_rs2;
            ex_d.rd      = i_id_rd;
            ex_d.rd_we   = i_id_rd_we;
            ex_d.is_load = i_id_is_load;
            ex_d.op1     = wb_hit_id1 ? i_wb_data : i_id_rs1_val;
            ex_d.op2     = wb_hit_id2 ? i_wb_data : i_id_rs2_val;
            ex_d.immu    = i_id_immu;
            ex_d.pc_immu = i_id_pc + i_id_immu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign o_num1u   = mem_hit1 ? i_mem_res : (wb_hit_q1 ? i_wb_data : ex_q.op1);
    assign o_num2u   = mem_hit2 ? i_mem_res : (wb_hit_q2 ? i_wb_data : ex_q.op2);
    assign o_valid   = ex_q.valid;
    assign o_opcode  = ex_q.opcode;
    assign o_funct7  = ex_q.funct7;
    assign o_funct3  = ex_q.funct3;
    assign o_immu    = ex_q.immu;
    assign o_pc_immu = ex_q.pc_immu;
    assign o_rd      = ex_q.rd;
    assign o_rd_we   = ex_q.rd_we;
    assign o_is_load = ex_q.is_load;
endmodule

// File: tb/tb_core_id_ex_stage.sv
// Bench for core_id_ex_stage: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a slot model.
module tb_core_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_id_valid, i_id_rd_we, i_id_is_load, i_stall, i_flush;
    logic [6:0]  i_id_opcode, i_id_funct7;
    logic [2:0]  i_id_funct3;
    logic [4:0]  i_id_rs1, i_id_rs2, i_id_rd, i_mem_rd, i_wb_rd;
    logic [31:0] i_id_rs1_val, i_id_rs2_val, i_id_immu, i_id_pc, i_mem_res, i_wb_data;
    logic        i_mem_rd_we, i_wb_rd_we;
    logic        o_valid, o_rd_we, o_is_load, o_load_use_stall;
    logic [6:0]  o_opcode, o_funct7;
    logic [2:0]  o_funct3;
    logic [31:0] o_num1u, o_num2u, o_immu, o_pc_immu;
    logic [4:0]  o_rd;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    core_id_ex_stage dut (
        .clk(clk), .rst(rst),
        .i_id_valid(i_id_valid), .i_id_opcode(i_id_opcode), .i_id_funct7(i_id_funct7),
        .i_id_funct3(i_id_funct3), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
        .i_id_rd_we(i_id_rd_we), .i_id_is_load(i_id_is_load), .i_id_rs1_val(i_id_rs1_val),
        .i_id_rs2_val(i_id_rs2_val), .i_id_immu(i_id_immu), .i_id_pc(i_id_pc),
        .i_stall(i_stall), .i_flush(i_flush),
        .i_mem_rd(i_mem_rd), .i_mem_rd_we(i_mem_rd_we), .i_mem_res(i_mem_res),
        .i_wb_rd(i_wb_rd), .i_wb_rd_we(i_wb_rd_we), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .o_opcode(o_opcode), .o_funct7(o_funct7), .o_funct3(o_funct3),
        .o_num1u(o_num1u), .o_num2u(o_num2u), .o_immu(o_immu), .o_pc_immu(o_pc_immu),
        .o_rd(o_rd), .o_rd_we(o_rd_we), .o_is_load(o_is_load),
        .o_load_use_stall(o_load_use_stall)
    );

    always #5 clk = ~clk;

    // The instruction occupying EX, as the specification describes it.
    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_we, is_load;
        logic [31:0] op1, op2, immu, pc_immu;
    } slot_t;

    slot_t m = '0;

    function automatic logic wb_writes(input logic [4:0] rs);
        return i_wb_rd_we && i_wb_rd == rs && rs != 0;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] stored);
        if (rs != 0 && i_mem_rd_we && i_mem_rd == rs) return i_mem_res;
        if (wb_writes(rs)) return i_wb_data;
        return stored;
    endfunction

    function automatic logic exp_lu();
        return m.valid && m.is_load && m.rd_we && m.rd != 0 && i_id_valid
               && (m.rd == i_id_rs1 || m.rd == i_id_rs2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else if (i_flush) m <= '0;
        else if (i_stall) begin
            if (wb_writes(m.rs1)) m.op1 <= i_wb_data;
            if (wb_writes(m.rs2)) m.op2 <= i_wb_data;
        end else if (exp_lu() || !i_id_valid) m <= '0;
        else begin
            m.valid   <= 1'b1;
            m.opcode  <= i_id_opcode;
            m.funct7  <= i_id_funct7;
            m.funct3  <= i_id_funct3;
            m.rs1     <= i_id_rs1;
            m.rs2     <= i_id_rs2;
            m.rd      <= i_id_rd;
            m.rd_we   <= i_id_rd_we;
            m.is_load <= i_id_is_load;
            m.op1     <= wb_writes(i_id_rs1) ? i_wb_data : i_id_rs1_val;
            m.op2     <= wb_writes(i_id_rs2) ? i_wb_data : i_id_rs2_val;
            m.immu    <= i_id_immu;
            m.pc_immu <= i_id_pc + i_id_immu;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",   32'(o_valid),   32'(m.valid));
            chk("opcode",  32'(o_opcode),  32'(m.opcode));
            chk("funct7",  32'(o_funct7),  32'(m.funct7));
            chk("funct3",  32'(o_funct3),  32'(m.funct3));
            chk("num1u",   o_num1u,        operand(m.rs1, m.op1));
            chk("num2u",   o_num2u,        operand(m.rs2, m.op2));
            chk("immu",    o_immu,         m.immu);
            chk("pc_immu", o_pc_immu,      m.pc_immu);
            chk("rd",      32'(o_rd),      32'(m.rd));
            chk("rd_we",   32'(o_rd_we),   32'(m.rd_we));
            chk("is_load", 32'(o_is_load), 32'(m.is_load));
            chk("lu",      32'(o_load_use_stall), 32'(exp_lu()));
        end
    end

    task automatic set_id(input logic v, input logic [6:0] op, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic we, input logic ld,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic [31:0] pc);
        i_id_valid = v; i_id_opcode = op; i_id_funct7 = f7; i_id_funct3 = f3;
        i_id_rs1 = r1; i_id_rs2 = r2; i_id_rd = rd; i_id_rd_we = we; i_id_is_load = ld;
        i_id_rs1_val = v1; i_id_rs2_val = v2; i_id_immu = imm; i_id_pc = pc;
    endtask

    task automatic idle_id();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_all();
        idle_id();
        i_stall = 0; i_flush = 0;
        i_mem_rd = 0; i_mem_rd_we = 0; i_mem_res = 0;
        i_wb_rd = 0; i_wb_rd_we = 0; i_wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_all();
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD x3,x1,x2
        set_id(1, 7'h33, 0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 32'd5, 32'd7, 0, 32'h100);
        tick(); idle_id(); #1;
        chk("add_opcode", 32'(o_opcode), 32'h33);
        chk("add_num1", o_num1u, 32'd5);
        chk("add_num2", o_num2u, 32'd7);
        chk("add_rd", 32'(o_rd), 32'd3);
        chk("add_valid", 32'(o_valid), 32'd1);

        // asynchronous reset mid-cycle
        rst = 1'b1; #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_opcode", 32'(o_opcode), 32'd0);
        chk("rst_num1", o_num1u, 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // MEM over WB, then WB alone, then x0
        set_id(1, 7'h33, 0, 0, 5'd4, 5'd2, 5'd8, 1, 0, 32'h99, 32'h5, 0, 0);
        tick(); idle_id();
        i_mem_rd = 5'd4; i_mem_rd_we = 1; i_mem_res = 32'h11;
        i_wb_rd = 5'd4; i_wb_rd_we = 1; i_wb_data = 32'h22; #1;
        chk("fwd_mem", o_num1u, 32'h11);
        i_mem_rd_we = 0; #1;
        chk("fwd_wb", o_num1u, 32'h22);
        tick();
        i_wb_rd_we = 0;
        set_id(1, 7'h33, 0, 0, 5'd0, 5'd2, 5'd9, 1, 0, 32'd0, 32'd3, 0, 0);
        tick(); idle_id();
        i_mem_rd = 5'd0; i_mem_rd_we = 1; i_mem_res = 32'h55; #1;
        chk("fwd_x0", o_num1u, 32'd0);
        i_mem_rd_we = 0;

        // LW x5 followed by ADDI x6,x5,1
        set_id(1, 7'h03, 0, 3'b010, 5'd2, 5'd0, 5'd5, 1, 1, 32'h1000, 0, 32'd4, 0);
        tick();
        set_id(1, 7'h13, 0, 0, 5'd5, 5'd1, 5'd6, 1, 0, 32'hDEAD, 0, 32'd1, 32'h8);
        #1 chk("lu_assert", 32'(o_load_use_stall), 32'd1);
        tick();
        i_mem_rd = 5'd5; i_mem_rd_we = 1; i_mem_res = 32'h1004; #1;
        chk("lu_bubble_op", 32'(o_opcode), 32'd0);
        chk("lu_bubble_valid", 32'(o_valid), 32'd0);
        chk("lu_release", 32'(o_load_use_stall), 32'd0);
        tick(); idle_id();
        i_mem_rd_we = 0; i_wb_rd = 5'd5; i_wb_rd_we = 1; i_wb_data = 32'h40; #1;
        chk("lu_addi_op", 32'(o_opcode), 32'h13);
        chk("lu_addi_num1", o_num1u, 32'h40);
        i_wb_rd_we = 0;

        // hold for three edges while WB retires x7 once
        set_id(1, 7'h33, 7'h20, 0, 5'd1, 5'd7, 5'd9, 1, 0, 32'd1, 32'h1111, 0, 0);
        tick();
        set_id(1, 7'h33, 0, 3'd1, 5'd3, 5'd3, 5'd10, 1, 0, 32'd9, 32'd9, 0, 0);
        i_stall = 1; tick();
        i_wb_rd = 5'd7; i_wb_rd_we = 1; i_wb_data = 32'hABCD; tick();
        i_wb_rd_we = 0; tick();
        i_stall = 0; idle_id(); #1;
        chk("hold_num2", o_num2u, 32'hABCD);
        chk("hold_num1", o_num1u, 32'd1);
        chk("hold_rd", 32'(o_rd), 32'd9);
        chk("hold_funct7", 32'(o_funct7), 32'h20);

        // flush beats stall
        set_id(1, 7'h33, 0, 0, 5'd1, 5'd2, 5'd11, 1, 0, 1, 2, 0, 0);
        tick();
        i_flush = 1; i_stall = 1; tick();
        i_flush = 0; i_stall = 0; idle_id(); #1;
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_rd_we", 32'(o_rd_we), 32'd0);
        chk("flush_opcode", 32'(o_opcode), 32'd0);

        // AUIPC wrap-around
        set_id(1, 7'h17, 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, 32'h2000, 32'hFFFFF000);
        tick(); idle_id(); #1;
        chk("auipc_wrap", o_pc_immu, 32'h1000);
        chk("auipc_imm", o_immu, 32'h2000);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_id($urandom_range(0, 7) != 0, 7'($urandom), 7'($urandom), 3'($urandom),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom, $urandom, $urandom, $urandom);
            i_stall = ($urandom_range(0, 5) == 0);
            i_flush = ($urandom_range(0, 15) == 0);
            i_mem_rd = 5'($urandom_range(0, 7)); i_mem_rd_we = $urandom_range(0, 1) == 1;
            i_mem_res = $urandom;
            i_wb_rd = 5'($urandom_range(0, 7)); i_wb_rd_we = $urandom_range(0, 1) == 1;
            i_wb_data = $urandom;
            tick();
        end
        rst = 1'b0;
        idle_all();
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
